// File: rtl/cpu_core_pkg.sv
// Shared definitions for the cpu_core family: opcode map, FSM states and
// the decoded control bundle that passes from the decoder to the datapath.
package lib_cpu;

    typedef enum logic [3:0] {
        ADD_A_IMM = 4'd0,
        ADD_B_IMM = 4'd1,
        MOV_A_IMM = 4'd2,
        MOV_B_IMM = 4'd3,
        MOV_A_B   = 4'd4,
        MOV_B_A   = 4'd5,
        JMP_IMM   = 4'd6,
        JNC_IMM   = 4'd7,
        IN_A      = 4'd8,
        IN_B      = 4'd9,
        OUT_B     = 4'd10,
        OUT_IMM   = 4'd11,
        ADD_A_B   = 4'd12,
        JC_IMM    = 4'd13,
        HALT      = 4'd14,
        ILLEGAL   = 4'd15
    } opecode_t;

    // State literals carry an ST_ prefix so they do not collide with the
    // HALT opcode inside this package.
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Source of the value written into a or b. SEL_XFER means "the other
    // register" (b when writing a, a when writing b).
    typedef enum logic [1:0] {
        SEL_IMM  = 2'd0,
        SEL_XFER = 2'd1,
        SEL_IN   = 2'd2,
        SEL_SUM  = 2'd3
    } src_sel_t;

    typedef struct packed {
        logic     wr_a;     // write register a
        logic     wr_b;     // write register b
        src_sel_t sel;      // write-data source
        logic     add;      // cf takes the adder carry instead of clearing
        logic     add_x_b;  // adder first operand is b (else a)
        logic     add_y_b;  // adder second operand is b (else imm)
        logic     jump;     // jump taken: ip <- imm
        logic     out_wr;   // write the out register
        logic     out_imm;  // out source is imm (else b)
        logic     halt;     // enter HALT, freeze ip and cf
        logic     illegal;  // reserved opcode executed
    } ctrl_t;

endpackage

// File: rtl/cpu_core_if.sv
// Instruction-memory handshake between cpu_core (master) and the ROM/RAM.
interface cpu_core_if #(parameter int DATA_W = 4);
    logic [DATA_W-1:0] imem_addr;
    logic              imem_req;
    logic              imem_ack;
    logic [DATA_W+3:0] imem_rdata;

    modport master (output imem_addr, output imem_req,
                    input  imem_ack,  input  imem_rdata);
    modport slave  (input  imem_addr, input  imem_req,
                    output imem_ack,  output imem_rdata);
endinterface

// File: rtl/cpu_core_decoder.sv
// Combinational opcode decoder: turns the latched opcode and the current
// carry flag into datapath controls. Conditional jumps resolve here.
module cpu_decoder
    import lib_cpu::*;
(
    input  opecode_t op,
    input  logic     cf,
    output ctrl_t    ctrl
);

    // Decode one opcode into the control bundle; everything defaults off.
    always_comb begin
        ctrl = '0;
        case (op)
            ADD_A_IMM: begin ctrl.wr_a = 1'b1; ctrl.sel = SEL_SUM; ctrl.add = 1'b1; end
            ADD_B_IMM: begin ctrl.wr_b = 1'b1; ctrl.sel = SEL_SUM; ctrl.add = 1'b1;
                             ctrl.add_x_b = 1'b1; end
            MOV_A_IMM: begin ctrl.wr_a = 1'b1; ctrl.sel = SEL_IMM; end
            MOV_B_IMM: begin ctrl.wr_b = 1'b1; ctrl.sel = SEL_IMM; end
            MOV_A_B:   begin ctrl.wr_a = 1'b1; ctrl.sel = SEL_XFER; end
            MOV_B_A:   begin ctrl.wr_b = 1'b1; ctrl.sel = SEL_XFER; end
            JMP_IMM:   ctrl.jump = 1'b1;
            JNC_IMM:   ctrl.jump = ~cf;
            IN_A:      begin ctrl.wr_a = 1'b1; ctrl.sel = SEL_IN; end
            IN_B:      begin ctrl.wr_b = 1'b1; ctrl.sel = SEL_IN; end
            OUT_B:     ctrl.out_wr = 1'b1;
            OUT_IMM:   begin ctrl.out_wr = 1'b1; ctrl.out_imm = 1'b1; end
            ADD_A_B:   begin ctrl.wr_a = 1'b1; ctrl.sel = SEL_SUM; ctrl.add = 1'b1;
                             ctrl.add_y_b = 1'b1; end
            JC_IMM:    ctrl.jump = cf;
            HALT:      ctrl.halt = 1'b1;
            ILLEGAL:   ctrl.illegal = 1'b1;
            default:   ctrl = '0;
        endcase
    end

endmodule

// File: rtl/cpu_core.sv
// Accumulator-style CPU with a DATA_W-bit datapath. Fetches over a req/ack
// handshake, executes one instruction per EXEC cycle, and parks in HALT.
module cpu_core
    import lib_cpu::*;
#(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    cpu_core_if.master        imem,
    input  logic [DATA_W-1:0] in_port,
    output logic [DATA_W-1:0] out_port,
    output logic              out_valid,
    output logic              halted,
    output logic              illegal
);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] ip;
        logic [DATA_W-1:0] out;
        logic              cf;
    } regs_t;

    state_t            state_q, state_d;
    regs_t             regs, regs_d;
    logic [DATA_W+3:0] ir;
    opecode_t          op;
    logic [DATA_W-1:0] imm;
    ctrl_t             ctrl;
    logic              exec;
    logic [DATA_W-1:0] add_x, add_y, wval;
    logic [DATA_W:0]   sum;

    assign op   = opecode_t'(ir[DATA_W+3:DATA_W]);
    assign imm  = ir[DATA_W-1:0];
    assign exec = (state_q == ST_EXEC);

    assign imem.imem_addr = regs.ip;
    assign imem.imem_req  = (state_q == ST_FETCH);
    assign halted         = (state_q == ST_HALT);
    assign out_port       = regs.out;

    cpu_decoder u_dec (
        .op   (op),
        .cf   (regs.cf),
        .ctrl (ctrl)
    );

    // Single shared adder; carry out lands in the top bit.
    assign add_x = ctrl.add_x_b ? regs.b : regs.a;
    assign add_y = ctrl.add_y_b ? regs.b : imm;
    assign sum   = {1'b0, add_x} + {1'b0, add_y};

    // Select the value written into a or b.
    always_comb begin
        wval = sum[DATA_W-1:0];
        case (ctrl.sel)
            SEL_IMM:  wval = imm;
            SEL_XFER: wval = ctrl.wr_a ? regs.b : regs.a;
            SEL_IN:   wval = in_port;
            default:  wval = sum[DATA_W-1:0];
        endcase
    end

    // Register updates for the instruction being executed; HALT freezes all.
    always_comb begin
        regs_d = regs;
        if (exec && !ctrl.halt) begin
            regs_d.ip = ctrl.jump ? imm : regs.ip + DATA_W'(1);
            regs_d.cf = ctrl.add ? sum[DATA_W] : 1'b0;
            if (ctrl.wr_a)   regs_d.a   = wval;
            if (ctrl.wr_b)   regs_d.b   = wval;
            if (ctrl.out_wr) regs_d.out = ctrl.out_imm ? imm : regs.b;
        end
    end

    // FSM next state: wait in FETCH for ack, one EXEC cycle, HALT absorbs.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: if (imem.imem_ack) state_d = ST_EXEC;
            ST_EXEC:  state_d = ctrl.halt ? ST_HALT : ST_FETCH;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_FETCH;
        endcase
    end

    // State, architectural registers, ir latch and the one-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            regs      <= '0;
            ir        <= '0;
            out_valid <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            state_q   <= state_d;
            regs      <= regs_d;
            if (state_q == ST_FETCH && imem.imem_ack) ir <= imem.imem_rdata;
            out_valid <= exec && ctrl.out_wr;
            illegal   <= exec && ctrl.illegal;
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// Scoreboard bench for cpu_core: a DATA_W=4 and a DATA_W=8 instance share
// clock and reset; each test loads a program that ends in HALT and queues
// the expected fetch addresses, register snapshots and output values.
module tb_cpu_core;

    typedef struct {
        int addr;
        int a;
        int b;
        int cf;
    } fexp_t;

    logic clk;
    logic rst_n;
    logic [3:0] in4, out4;
    logic [7:0] in8, out8;
    logic ov4, ov8, h4, h8, il4, il8;

    logic [7:0]  mem4 [16];
    logic [11:0] mem8 [256];
    int wait_n;
    int cnt4, cnt8;
    int cyc;
    int n_chk, n_pass;
    int first_out4;
    int ill8;
    bit on4, on8;
    fexp_t fq4[$], fq8[$];
    int oq4[$], oq8[$];
    fexp_t e4, e8;
    bit prev_wait4, prev_wait8;
    logic [3:0] prev_addr4;
    logic [7:0] prev_addr8;
    logic [63:0] prev_regs4;

    cpu_core_if #(.DATA_W(4)) if4 ();
    cpu_core_if #(.DATA_W(8)) if8 ();

    cpu_core #(.DATA_W(4)) u4 (
        .clk(clk), .rst_n(rst_n), .imem(if4), .in_port(in4),
        .out_port(out4), .out_valid(ov4), .halted(h4), .illegal(il4)
    );

    cpu_core #(.DATA_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .imem(if8), .in_port(in8),
        .out_port(out8), .out_valid(ov8), .halted(h8), .illegal(il8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory models: ack after wait_n request cycles, data read by address.
    always @(posedge clk) begin
        if (!rst_n || !if4.imem_req || if4.imem_ack) cnt4 <= 0; else cnt4 <= cnt4 + 1;
        if (!rst_n || !if8.imem_req || if8.imem_ack) cnt8 <= 0; else cnt8 <= cnt8 + 1;
        if (!rst_n) cyc <= 0; else cyc <= cyc + 1;
    end
    assign if4.imem_ack   = if4.imem_req && (cnt4 >= wait_n);
    assign if4.imem_rdata = mem4[if4.imem_addr];
    assign if8.imem_ack   = if8.imem_req && (cnt8 >= wait_n);
    assign if8.imem_rdata = mem8[if8.imem_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    task automatic fx4(input int addr, input int a = -1, input int b = -1, input int cf = -1);
        fexp_t e;
        e.addr = addr; e.a = a; e.b = b; e.cf = cf;
        fq4.push_back(e);
    endtask

    task automatic fx8(input int addr, input int a = -1, input int b = -1, input int cf = -1);
        fexp_t e;
        e.addr = addr; e.a = a; e.b = b; e.cf = cf;
        fq8.push_back(e);
    endtask

    // Scoreboard for the 4-bit core.
    always @(negedge clk) begin
        if (rst_n && on4) begin
            if (if4.imem_req && if4.imem_ack) begin
                if (fq4.size() == 0) chk("fetch4_extra", 1, 0);
                else begin
                    e4 = fq4.pop_front();
                    chk("fetch4_addr", if4.imem_addr, e4.addr);
                    if (e4.a >= 0)  chk("a4", u4.regs.a, e4.a);
                    if (e4.b >= 0)  chk("b4", u4.regs.b, e4.b);
                    if (e4.cf >= 0) chk("cf4", u4.regs.cf, e4.cf);
                end
            end
            if (if4.imem_req && !if4.imem_ack && prev_wait4) begin
                chk("addr4_stable", if4.imem_addr, prev_addr4);
                chk("regs4_stable", u4.regs, prev_regs4);
            end
            prev_wait4 = if4.imem_req && !if4.imem_ack;
            prev_addr4 = if4.imem_addr;
            prev_regs4 = 64'(u4.regs);
            if (ov4) begin
                if (oq4.size() == 0) chk("out4_extra", 1, 0);
                else chk("out4", out4, oq4.pop_front());
                if (first_out4 < 0) first_out4 = cyc;
            end
        end else begin
            prev_wait4 = 1'b0;
        end
    end

    // Scoreboard for the 8-bit core.
    always @(negedge clk) begin
        if (rst_n && on8) begin
            if (if8.imem_req && if8.imem_ack) begin
                if (fq8.size() == 0) chk("fetch8_extra", 1, 0);
                else begin
                    e8 = fq8.pop_front();
                    chk("fetch8_addr", if8.imem_addr, e8.addr);
                    if (e8.a >= 0)  chk("a8", u8.regs.a, e8.a);
                    if (e8.b >= 0)  chk("b8", u8.regs.b, e8.b);
                    if (e8.cf >= 0) chk("cf8", u8.regs.cf, e8.cf);
                end
            end
            if (if8.imem_req && !if8.imem_ack && prev_wait8)
                chk("addr8_stable", if8.imem_addr, prev_addr8);
            prev_wait8 = if8.imem_req && !if8.imem_ack;
            prev_addr8 = if8.imem_addr;
            if (ov8) begin
                if (oq8.size() == 0) chk("out8_extra", 1, 0);
                else chk("out8", out8, oq8.pop_front());
            end
            if (il8) ill8++;
        end else begin
            prev_wait8 = 1'b0;
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 16; i++)  mem4[i] = 8'hE0;
        for (int i = 0; i < 256; i++) mem8[i] = 12'hE00;
    endtask

    // Reset both cores, then release just after a rising edge.
    task automatic start(input bit sel8, input int wn);
        wait_n = wn;
        first_out4 = -1;
        ill8 = 0;
        on4 = 1'b0; on8 = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        on4 = !sel8;
        on8 = sel8;
    endtask

    // Run until the selected core halts, then require drained queues.
    task automatic finish_run(input bit sel8, input int budget);
        int k;
        k = 0;
        while (!(sel8 ? h8 : h4) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) chk(sel8 ? "halt8_timeout" : "halt4_timeout", 0, 1);
        @(negedge clk);
        if (sel8) begin
            chk("fq8_left", fq8.size(), 0);
            chk("oq8_left", oq8.size(), 0);
        end else begin
            chk("fq4_left", fq4.size(), 0);
            chk("oq4_left", oq4.size(), 0);
        end
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst_n = 1'b0; on4 = 1'b0; on8 = 1'b0;
        in4 = 4'h0; in8 = 8'h00; wait_n = 0;
        clear_mem();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out", out4, 0);
        chk("rst_out_valid", ov4, 0);
        chk("rst_halted", h4, 0);
        chk("rst_illegal", il4, 0);
        chk("rst_req", if4.imem_req, 1);
        chk("rst_addr", if4.imem_addr, 0);

        // Add with carry, OUT_IMM, zero-wait timing
        clear_mem();
        mem4[0] = 8'h23; mem4[1] = 8'h0E; mem4[2] = 8'hB5; mem4[3] = 8'hE0;
        fx4(0); fx4(1); fx4(2, 1, -1, 1); fx4(3, -1, -1, 0);
        oq4.push_back(5);
        start(1'b0, 0);
        finish_run(1'b0, 100);
        chk("out_cycle_w0", first_out4, 6);

        // Same program with three wait cycles per fetch
        fx4(0); fx4(1); fx4(2, 1, -1, 1); fx4(3, -1, -1, 0);
        oq4.push_back(5);
        start(1'b0, 3);
        finish_run(1'b0, 200);
        chk("out_cycle_w3", first_out4, 15);

        // Jumps on carry and ip wrap from 15 to 0
        clear_mem();
        mem4[0]  = 8'h7A; mem4[1]  = 8'h2F; mem4[2]  = 8'h01; mem4[3]  = 8'hD9;
        mem4[9]  = 8'hE0; mem4[10] = 8'h2F; mem4[11] = 8'h01; mem4[12] = 8'h73;
        mem4[13] = 8'h2E; mem4[14] = 8'h01; mem4[15] = 8'h01;
        fx4(0); fx4(10); fx4(11); fx4(12, 0, -1, 1); fx4(13, -1, -1, 0);
        fx4(14); fx4(15, 15, -1, 0); fx4(0, 0, -1, 1); fx4(1, -1, -1, 0);
        fx4(2); fx4(3, 0, -1, 1); fx4(9, -1, -1, 0);
        start(1'b0, 0);
        finish_run(1'b0, 200);
        chk("jc_halt_addr", if4.imem_addr, 9);

        // 8-bit datapath: ADD_A_B carry, IN_B, OUT_B, illegal opcode
        clear_mem();
        in8 = 8'hA5;
        mem8[0] = 12'h2C8; mem8[1] = 12'h364; mem8[2] = 12'hC00; mem8[3] = 12'h900;
        mem8[4] = 12'hA00; mem8[5] = 12'h500; mem8[6] = 12'hA00; mem8[7] = 12'hF00;
        mem8[8] = 12'hB3C; mem8[9] = 12'hE00;
        fx8(0); fx8(1); fx8(2, 200, 100, 0); fx8(3, 44, 100, 1);
        fx8(4, 44, 8'hA5, 0); fx8(5); fx8(6, 44, 44, 0); fx8(7);
        fx8(8, -1, -1, 0); fx8(9);
        oq8.push_back(8'hA5); oq8.push_back(8'h2C); oq8.push_back(8'h3C);
        start(1'b1, 0);
        finish_run(1'b1, 200);
        chk("illegal_pulses", ill8, 1);

        // HALT at ip=2 is permanent
        clear_mem();
        mem4[0] = 8'h33; mem4[1] = 8'hA0; mem4[2] = 8'hE0;
        fx4(0); fx4(1); fx4(2);
        oq4.push_back(3);
        start(1'b0, 0);
        finish_run(1'b0, 100);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("halt_flag", h4, 1);
            chk("halt_req", if4.imem_req, 0);
            chk("halt_ip", if4.imem_addr, 2);
        end

        // Reset in the middle of an OUT_IMM execute
        clear_mem();
        mem4[0] = 8'hB5; mem4[1] = 8'hE0;
        fx4(0);
        start(1'b0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", ov4, 0);
        chk("abort_out", out4, 0);
        chk("abort_ip", if4.imem_addr, 0);
        chk("abort_req", if4.imem_req, 1);
        @(negedge clk);
        chk("abort_out_valid2", ov4, 0);
        fx4(0); fx4(1);
        oq4.push_back(5);
        start(1'b0, 0);
        finish_run(1'b0, 100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cpu_core.md
# cpu_core

Parametrised successor of the team's 4-bit two-register CPU. The accumulator-style core (registers a, b, ip, out, cf) is generalised to a DATA_W-bit datapath. It fetches from an external instruction memory over a req/ack handshake instead of a combinational ROM. It adds ADD_A_B, JC_IMM, HALT, an output strobe, and illegal-opcode reporting. It sits between the board-level instruction ROM/RAM and the LED/switch I/O.

## Interface
- DATA_W, default 4: width of a, b, out, ip, immediate and input port; minimum 4.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_addr  out  DATA_W  instruction address, equals ip.
- imem_req  out  1  fetch request, high exactly while in FETCH.
- imem_ack  in  1  rdata valid this cycle.
- imem_rdata  in  4+DATA_W  instruction {opcode[3:0], imm[DATA_W-1:0]}.
- in_port  in  DATA_W  input switches, sampled in EXEC.
- out_port  out  DATA_W  out register.
- out_valid  out  1  one-cycle pulse, the cycle after out is written.
- halted  out  1  high while in HALT.
- illegal  out  1  one-cycle pulse, the cycle after an opcode-15 EXEC.

## Operation
- Opcode encodings (fixed):
  - 0 ADD_A_IMM; 1 ADD_B_IMM; 2 MOV_A_IMM; 3 MOV_B_IMM
  - 4 MOV_A_B (a←b); 5 MOV_B_A (b←a); 6 JMP_IMM; 7 JNC_IMM
  - 8 IN_A; 9 IN_B; 10 OUT_B; 11 OUT_IMM
  - 12 ADD_A_B (a←a+b); 13 JC_IMM; 14 HALT; 15 reserved
- States:
  - FETCH: on imem_ack, latch imem_rdata into ir, go to EXEC. Without ack, stay in FETCH with addr and req stable.
  - EXEC: commit one instruction, then go to FETCH, or to HALT if opcode is 14.
  - HALT: absorbing; leave only via reset.
- Add arithmetic: {cf, dst} ← dst + src computed at DATA_W+1 bits; cf is the carry out.
- Every executed non-ADD instruction except HALT clears cf. HALT leaves cf unchanged.
- Jump tests use cf as it was before the jump. JNC is taken when cf=0; JC is taken when cf=1. In both cases cf is then cleared.
- ip: a taken jump loads imm. Otherwise ip ← ip+1 modulo 2^DATA_W, so ip wraps from all-ones to 0. HALT does not advance ip.
- Opcode 15: behaves as NOP (ip+1, cf←0) and pulses illegal.

## Timing
- Reset values: a=b=ip=out=cf=0, state FETCH, out_valid=0, halted=0, illegal=0, ir=0.
- imem_req is decoded from state, so it reads 1 while held in reset. imem_ack is ignored while rst_n=0.
- Zero-wait memory (ack in the first FETCH cycle): 2 cycles per instruction.
- Each wait cycle adds 1 cycle. ack may arrive any number of cycles after req.
- Register writes take effect at the clock edge that ends EXEC, and are visible in the next FETCH.
- out_valid and illegal are asserted in the cycle after EXEC, for exactly one cycle.
- Reset asserted in any state aborts the current fetch or execute immediately. A pending ack is discarded. Restart is at ip=0.

## Structure
- The shared package lib_cpu carries:
  - OPECODE enum with the explicit 4-bit encodings above; INVALID is replaced by ILLEGAL=15.
  - STATE enum {FETCH, EXEC, HALT}.
- The register struct is declared inside the module, because it depends on DATA_W.
- Sub-module cpu_decoder (combinational): opcode + cf → register-select, load, jump-taken, out-write and illegal controls. cpu_core holds the FSM, registers and adder.

## Test plan
- DATA_W=4, zero-wait ROM: MOV_A_IMM 3; ADD_A_IMM 14; OUT_IMM 5 → a=1, cf=1 after the ADD; cf=0 after OUT_IMM. out_port=5 with one out_valid pulse; 6 cycles total.
- Wrap: ip=15 executing a non-jump → next imem_addr=0. JNC_IMM 9 with cf=1 → not taken, ip+1. JC_IMM 9 with cf=1 → ip=9.
- Handshake: ack delayed 3 cycles on every fetch → imem_addr stays stable and no register changes during the wait; 5 cycles per instruction.
- DATA_W=8: ADD_A_B with a=200, b=100 → a=44, cf=1. IN_B with in_port=0xA5 → b=0xA5.
- HALT at ip=2 → halted=1 permanently, imem_req=0, ip stays 2. Opcode 15 → one illegal pulse, then execution continues.
- Reset mid-EXEC of OUT_IMM → no out_valid, out=0, ip=0, state FETCH on release.
